// File: rtl/inst_prefetch.sv
// Instruction prefetch queue: fetches sequential words ahead of the consumer and flushes on branch redirect.
// Optional stall counter output enabled by defining INST_PREFETCH_STATS_EN.
//
// state | meaning
// IDLE  | no request in flight; issues one whenever the queue has room
// REQ   | request at fetch_pc on the bus, back-to-back until the queue fills
// DRAIN | redirected while a request was pending; hold old address, discard its word
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        write_ir,
    output logic [31:0] IR,
    output logic        W_IR_valid,
`ifdef INST_PREFETCH_STATS_EN
    output logic [15:0] stall_cnt,
`endif
    output logic [31:0] ir_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc, drain_addr;
    logic          full, req_active, push, pop, fill_last;
    logic          unused_ok;

    assign unused_ok  = ^branch_target[1:0];
    assign full       = (count == DEPTH_C);
    // IDLE with room presents its request combinationally so the first fetch follows reset release
    assign req_active = (state == REQ) || (state == DRAIN) || (state == IDLE && !full);
    assign push       = mem_req && mem_ack && (state != DRAIN) && !branch_valid;
    assign pop        = write_ir && (count != '0) && !branch_valid;
    assign fill_last  = push && !pop && (count == DEPTH_C - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DRAIN: if (mem_ack) state_nxt = REQ;
            default: begin
                if (req_active) begin
                    if (branch_valid)  state_nxt = mem_ack ? REQ : DRAIN;
                    else if (mem_ack)  state_nxt = fill_last ? IDLE : REQ;
                    else               state_nxt = REQ;
                end else if (branch_valid) begin
                    state_nxt = REQ;
                end
            end
        endcase
    end

    always_comb begin
        mem_req    = req_active && !rst;
        mem_addr   = (state == DRAIN) ? drain_addr : fetch_pc;
        W_IR_valid = (count != '0);
        IR         = W_IR_valid ? q_data[head] : 32'h0;
        ir_pc      = W_IR_valid ? q_pc[head]   : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            // frozen while draining so the abandoned address stays on the bus
            if (state != DRAIN) drain_addr <= fetch_pc;
            if (branch_valid) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= {branch_target[31:2], 2'b00};
            end else begin
                if (push) begin
                    q_data[tail] <= mem_rdata;
                    q_pc[tail]   <= fetch_pc;
                    tail         <= tail + PW'(1);
                    fetch_pc     <= fetch_pc + 32'd4;
                end
                if (pop) head <= head + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef INST_PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'h0;
        else if (!W_IR_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, is the instruction queue depth in entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mem_req  output  1  instruction memory request valid.
REQ-006 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-007 mem_ack  input  1  memory accepts request and returns mem_rdata in the same cycle.
REQ-008 mem_rdata  input  32  instruction word, sampled only when mem_req=1 and mem_ack=1.
REQ-009 branch_valid  input  1  redirect: flush queue and refetch from branch_target.
REQ-010 branch_target  input  32  redirect address; bits [1:0] forced to 0.
REQ-011 write_ir  input  1  consumer pops queue head (controller IR load).
REQ-012 IR  output  32  queue head instruction; 0 when queue empty.
REQ-013 W_IR_valid  output  1  queue non-empty; IR is valid.
REQ-014 ir_pc  output  32  fetch address of the instruction presented on IR.

Function
REQ-015 The block SHALL hold at most one outstanding memory request; mem_req and mem_addr SHALL stay stable from assertion until the cycle mem_ack=1.
REQ-016 FSM states IDLE, REQ, DRAIN; IDLE->REQ when count+1 <= DEPTH and no flush pending; REQ->IDLE on ack when the queue would become full, otherwise REQ->REQ with mem_addr+4 on the next cycle (back-to-back fetch).
REQ-017 On mem_ack in REQ without branch_valid, mem_rdata and mem_addr SHALL be pushed at the tail and fetch_pc SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 A new request SHALL NOT be issued when count == DEPTH; mem_ack is therefore never received while full.
REQ-019 IR, ir_pc, W_IR_valid SHALL be driven combinationally from registered queue storage (head entry, count != 0).
REQ-020 write_ir with W_IR_valid=1 SHALL pop the head; write_ir with queue empty SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-022 branch_valid SHALL empty the queue and set fetch_pc to {branch_target[31:2],2'b00} in the same edge; W_IR_valid SHALL be 0 the following cycle.
REQ-023 branch_valid while in REQ without mem_ack SHALL move the FSM to DRAIN: mem_req and the old mem_addr held until mem_ack, the returned word discarded, then REQ at the target address on the next cycle.
REQ-024 branch_valid coincident with mem_ack SHALL discard that word and issue the target request on the next cycle.
REQ-025 branch_valid coincident with write_ir SHALL give the branch priority; the pop has no further effect.
REQ-026 branch_valid in DRAIN SHALL update the target only; the FSM remains in DRAIN.
REQ-027 Minimum latency: request issued cycle N with mem_ack=1 -> W_IR_valid=1 in cycle N+1.

Reset
REQ-028 With rst=1 at a rising edge: queue count=0, pointers=0, FSM=IDLE, fetch_pc=RESET_PC; outputs mem_req=0, mem_addr=RESET_PC, IR=0, ir_pc=0, W_IR_valid=0.
REQ-029 rst mid-request SHALL abandon the request without waiting for mem_ack; any ack arriving during rst is ignored.
REQ-030 First mem_req=1 with mem_addr=RESET_PC SHALL appear in the first cycle after rst deasserts.

Configuration
REQ-031 With macro INST_PREFETCH_STATS_EN defined, output stall_cnt (16 bits) SHALL count cycles with W_IR_valid=0 after reset, saturating at 16'hFFFF, cleared by rst; without the macro the port and counter SHALL not exist.

Verification
REQ-032 Reset release, mem_ack tied 1 -> mem_addr 0,4,8,12 on consecutive cycles; W_IR_valid=1 from cycle 2; fetch stalls with count=4 and write_ir=0.
REQ-033 Queue full (4 entries 0x0..0xC), write_ir pulse -> IR changes from word@0x0 to word@0x4, ir_pc=0x4, exactly one new request at 0x10.
REQ-034 Request at 0x8 outstanding, mem_ack held low, branch_valid with target 0x103 -> mem_addr stays 0x8 until ack, word discarded, next request at 0x100.
REQ-035 branch_valid, write_ir and mem_ack in the same cycle -> queue empty next cycle, next mem_addr = target, W_IR_valid=0.
REQ-036 fetch_pc at 0xFFFF_FFFC with ack -> next mem_addr 0x0000_0000.
REQ-037 With INST_PREFETCH_STATS_EN, mem_ack held 0 for 20 cycles after reset -> stall_cnt=20; rst=1 -> stall_cnt=0.
